// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage: program-counter and IF/ID register block for the RV32I pipeline.
// Holds the fetch PC, selects the next PC (sequential, PC-relative, JALR, trap),
// handles stall/flush, registers the IF/ID fields and flags misaligned redirect
// targets by diverting to the trap vector.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   stall_f       hold PC and IF/ID (ignored by the PC when a redirect is present)
//   flush_d       invalidate IF/ID on the next edge
//   pc_src        00 seq, 01 PC-relative, 10 JALR, 11 trap
//   imm_ext       sign-extended immediate for PC-relative target
//   pc_base_e     PC of the redirecting execute-stage instruction
//   pc_jalr       rs1+imm from the ALU for JALR
//   pc_f          current fetch PC
//   pc_d          IF/ID PC
//   pc_plus_d     IF/ID PC+INSTR_BYTES
//   valid_d       IF/ID holds a real instruction
//   misalign_trap one-cycle pulse after a misaligned redirect
module fetch_pc_stage #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(4),
    parameter int unsigned      INSTR_BYTES  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_f,
    input  logic             flush_d,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] imm_ext,
    input  logic [WIDTH-1:0] pc_base_e,
    input  logic [WIDTH-1:0] pc_jalr,
    output logic [WIDTH-1:0] pc_f,
    output logic [WIDTH-1:0] pc_d,
    output logic [WIDTH-1:0] pc_plus_d,
    output logic             valid_d,
    output logic             misalign_trap
);

    localparam logic [1:0] SRC_SEQ  = 2'b00;
    localparam logic [1:0] SRC_REL  = 2'b01;
    localparam logic [1:0] SRC_JALR = 2'b10;
    localparam logic [1:0] SRC_TRAP = 2'b11;

    // Low address bits that must be zero for an aligned instruction fetch.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);
    localparam logic [WIDTH-1:0] INCR       = WIDTH'(INSTR_BYTES);

    logic [WIDTH-1:0] r_pc_f;
    logic [WIDTH-1:0] r_pc_d;
    logic [WIDTH-1:0] r_pc_plus_d;
    logic             r_valid_d;
    logic             r_misalign_trap;

    logic [WIDTH-1:0] w_pc_plus_f;
    logic [WIDTH-1:0] w_target_rel;
    logic [WIDTH-1:0] w_target_jalr;
    logic [WIDTH-1:0] w_target_sel;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_redirect;
    logic             w_misaligned;

    // Candidate targets; additions wrap modulo 2^WIDTH.
    assign w_pc_plus_f   = r_pc_f + INCR;
    assign w_target_rel  = pc_base_e + imm_ext;
    assign w_target_jalr = pc_jalr & ~WIDTH'(1);
    assign w_redirect    = (pc_src != SRC_SEQ);

    // Next-PC mux; only the two computed redirect targets can be misaligned.
    always_comb begin
        w_target_sel = w_pc_plus_f;
        w_misaligned = 1'b0;
        case (pc_src)
            SRC_SEQ:  w_target_sel = w_pc_plus_f;
            SRC_REL:  begin
                w_target_sel = w_target_rel;
                w_misaligned = |(w_target_rel & ALIGN_MASK);
            end
            SRC_JALR: begin
                w_target_sel = w_target_jalr;
                w_misaligned = |(w_target_jalr & ALIGN_MASK);
            end
            SRC_TRAP: w_target_sel = TRAP_VECTOR;
            default:  w_target_sel = w_pc_plus_f;
        endcase
        w_next_pc = w_misaligned ? TRAP_VECTOR : w_target_sel;
    end

    // PC and IF/ID state. Redirects move the PC even under stall but never
    // write IF/ID; flush clears valid and holds the IF/ID payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_f          <= RESET_VECTOR;
            r_pc_d          <= '0;
            r_pc_plus_d     <= '0;
            r_valid_d       <= 1'b0;
            r_misalign_trap <= 1'b0;
        end else begin
            r_misalign_trap <= w_misaligned;
            if (w_redirect || !stall_f) begin
                r_pc_f <= w_next_pc;
            end
            if (flush_d) begin
                r_valid_d <= 1'b0;
            end else if (!w_redirect && !stall_f) begin
                r_pc_d      <= r_pc_f;
                r_pc_plus_d <= w_pc_plus_f;
                r_valid_d   <= 1'b1;
            end
        end
    end

    assign pc_f          = r_pc_f;
    assign pc_d          = r_pc_d;
    assign pc_plus_d     = r_pc_plus_d;
    assign valid_d       = r_valid_d;
    assign misalign_trap = r_misalign_trap;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Testbench for fetch_pc_stage: directed scenarios followed by random stimulus,
// all checked against a behavioural reference model of the fetch stage.
module tb_fetch_pc_stage;

    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] TV   = 32'h0000_0004;
    localparam longint      STEP = 4;
    localparam longint      MOD  = 64'd1 << 32;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        flush_d;
    logic [1:0]  pc_src;
    logic [31:0] imm_ext;
    logic [31:0] pc_base_e;
    logic [31:0] pc_jalr;
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic [31:0] pc_plus_d;
    logic        valid_d;
    logic        misalign_trap;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_pc_d;
    logic [31:0] m_pc_plus_d;
    logic        m_valid;
    logic        m_trap;

    int n_checks = 0;
    int n_errors = 0;

    fetch_pc_stage #(
        .WIDTH(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .INSTR_BYTES(4)
    ) dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .flush_d(flush_d),
        .pc_src(pc_src), .imm_ext(imm_ext), .pc_base_e(pc_base_e),
        .pc_jalr(pc_jalr), .pc_f(pc_f), .pc_d(pc_d), .pc_plus_d(pc_plus_d),
        .valid_d(valid_d), .misalign_trap(misalign_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        longint tgt;
        bit     redirect;
        bit     mis;
        if (rst) begin
            m_pc = RV; m_pc_d = '0; m_pc_plus_d = '0; m_valid = 1'b0; m_trap = 1'b0;
            return;
        end
        redirect = (pc_src != 2'd0);
        case (pc_src)
            2'd0:    tgt = (longint'(m_pc) + STEP) % MOD;
            2'd1:    tgt = (longint'(pc_base_e) + longint'(imm_ext)) % MOD;
            2'd2:    tgt = longint'(pc_jalr) - (longint'(pc_jalr) % 2);
            default: tgt = longint'(TV);
        endcase
        mis = (pc_src == 2'd1 || pc_src == 2'd2) && (tgt % STEP != 0);
        if (flush_d) begin
            m_valid = 1'b0;
        end else if (!redirect && !stall_f) begin
            m_pc_d      = m_pc;
            m_pc_plus_d = 32'((longint'(m_pc) + STEP) % MOD);
            m_valid     = 1'b1;
        end
        if (redirect || !stall_f) m_pc = mis ? TV : 32'(tgt);
        m_trap = mis;
    endtask

    // One clock edge, then sample 1 time unit later and compare everything.
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        model_edge();
        check({tag, ".pc_f"}, pc_f, m_pc);
        check({tag, ".pc_d"}, pc_d, m_pc_d);
        check({tag, ".pc_plus_d"}, pc_plus_d, m_pc_plus_d);
        check({tag, ".valid_d"}, 32'(valid_d), 32'(m_valid));
        check({tag, ".trap"}, 32'(misalign_trap), 32'(m_trap));
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic [1:0] src);
        rst = r; stall_f = s; flush_d = f; pc_src = src;
    endtask

    initial begin
        m_pc = '0; m_pc_d = '0; m_pc_plus_d = '0; m_valid = 1'b0; m_trap = 1'b0;
        imm_ext = '0; pc_base_e = '0; pc_jalr = '0;
        drive(1'b1, 1'b0, 1'b0, 2'd0);

        // Reset then free-running sequential fetch
        tick("reset");
        check("reset.pc_const", pc_f, 32'h0);
        check("reset.valid_const", 32'(valid_d), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        tick("seq1");
        check("seq1.pc_const", pc_f, 32'h4);
        tick("seq2");
        tick("seq3");
        check("seq3.pc_const", pc_f, 32'hC);
        check("seq3.pcd_const", pc_d, 32'h8);

        // PC-relative redirect with negative offset and flush
        pc_base_e = 32'h100; imm_ext = 32'hFFFF_FFF0;
        drive(1'b0, 1'b0, 1'b1, 2'd1);
        tick("rel");
        check("rel.pc_const", pc_f, 32'hF0);
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        tick("rel_after");
        check("rel_after.pcd_const", pc_d, 32'hF0);

        // Misaligned JALR target diverts to the trap vector for one pulse
        pc_jalr = 32'h203;
        drive(1'b0, 1'b0, 1'b1, 2'd2);
        tick("jalr_mis");
        check("jalr_mis.pc_const", pc_f, TV);
        check("jalr_mis.trap_const", 32'(misalign_trap), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        tick("jalr_mis_after");
        check("jalr_mis_after.trap_const", 32'(misalign_trap), 32'h0);

        // Stall at 0x20, then trap redirect overriding stall
        pc_base_e = 32'h1C; imm_ext = 32'h0;
        drive(1'b0, 1'b0, 1'b1, 2'd1);
        tick("to1c");
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        tick("to20");
        check("to20.pc_const", pc_f, 32'h20);
        drive(1'b0, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) tick("stall");
        check("stall.pc_const", pc_f, 32'h20);
        check("stall.pcd_const", pc_d, 32'h1C);
        drive(1'b0, 1'b1, 1'b1, 2'd3);
        tick("stall_trap");
        check("stall_trap.pc_const", pc_f, TV);
        check("stall_trap.trap_const", 32'(misalign_trap), 32'h0);

        // Wrap from the top of the address space
        pc_base_e = 32'hFFFF_FFFC; imm_ext = 32'h0;
        drive(1'b0, 1'b0, 1'b1, 2'd1);
        tick("to_top");
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        tick("wrap");
        check("wrap.pc_const", pc_f, 32'h0);
        check("wrap.pcplus_const", pc_plus_d, 32'h0);

        // Reset during redirect+stall+flush, then a reset glitch between edges
        pc_base_e = 32'h400; imm_ext = 32'h40;
        drive(1'b1, 1'b1, 1'b1, 2'd1);
        tick("rst_mid");
        check("rst_mid.pc_const", pc_f, RV);
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        tick("post_rst");
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick("glitch");
        check("glitch.pc_const", pc_f, 32'h8);

        // Random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 40) == 0);
            stall_f   = ($urandom_range(0, 3) == 0);
            flush_d   = ($urandom_range(0, 3) == 0);
            pc_src    = ($urandom_range(0, 2) == 0) ? 2'(($urandom_range(1, 3))) : 2'd0;
            pc_base_e = $urandom;
            imm_ext   = ($urandom_range(0, 1) == 1) ? ($urandom & ~32'h3) : $urandom;
            pc_jalr   = $urandom;
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
